// File: rtl/burst_line_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : burst_line_writer_pkg
//  Brief    : BurstRAM command encodings and writer state enum, shared with
//             the cache modules.
//  Revision : 1.0 - initial release
// ============================================================================
package burst_line_writer_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RAM = 2'd1,
        ST_BURST    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/burst_line_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : burst_line_writer_if
//  Brief    : Request side and BurstRAM write side of the line writer.
//  Revision : 1.0 - initial release
// ============================================================================
interface burst_line_writer_if #(
    parameter int ADDRESS_BITWIDTH        = 32,
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
);
    localparam int LINE_BITS = RAM_BURST_DATA_COUNT * RAM_BURST_DATA_BITWIDTH;

    logic                                 enable;
    logic [ADDRESS_BITWIDTH-1:0]          address;
    logic [LINE_BITS-1:0]                 line_data;
    logic [LINE_BITS/8-1:0]               line_mask;
    logic                                 busy;
    logic                                 done;

    logic                                 br_cmd;
    logic                                 br_cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data;
    logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask;
    logic                                 br_busy;

    logic [31:0]                          stat_writes;
    logic [31:0]                          stat_skipped;

    modport slave (
        input  enable, address, line_data, line_mask, br_busy,
        output busy, done, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
        output stat_writes, stat_skipped
    );

    modport master (
        output enable, address, line_data, line_mask, br_busy,
        input  busy, done, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
        input  stat_writes, stat_skipped
    );

endinterface
`default_nettype wire

// File: rtl/burst_line_writer_line_beat_mux.sv
`default_nettype none
// ============================================================================
//  Module   : line_beat_mux
//  Brief    : Selects one beat of data and its byte-dirty mask from a line.
//  Revision : 1.0 - initial release
// ============================================================================
module line_beat_mux #(
    parameter int BEAT_BITS  = 64,
    parameter int BEAT_COUNT = 4,
    parameter int IDX_W      = 3
) (
    input  wire logic [BEAT_COUNT*BEAT_BITS-1:0]   line_data,
    input  wire logic [BEAT_COUNT*BEAT_BITS/8-1:0] line_mask,
    input  wire logic [IDX_W-1:0]                  beat,
    output logic      [BEAT_BITS-1:0]              data,
    output logic      [BEAT_BITS/8-1:0]            dirty
);
    localparam int MASK_BITS = BEAT_BITS / 8;

    // An index past the last beat selects nothing (zero data, nothing dirty).
    always_comb begin
        data  = '0;
        dirty = '0;
        for (int k = 0; k < BEAT_COUNT; k++) begin
            if (beat == IDX_W'(k)) begin
                data  = line_data[k*BEAT_BITS +: BEAT_BITS];
                dirty = line_mask[k*MASK_BITS +: MASK_BITS];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/burst_line_writer.sv
`default_nettype none
// ============================================================================
//  Module   : burst_line_writer
//  Brief    : Writes one cache line with a byte-dirty mask to BurstRAM as a
//             single write burst.
//  Revision : 1.0 - initial release
// ============================================================================
module burst_line_writer
    import burst_line_writer_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH        = 32,
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    burst_line_writer_if.slave   bus
);
    localparam int W         = RAM_BURST_DATA_BITWIDTH;
    localparam int LINE_BITS = RAM_BURST_DATA_COUNT * W;
    localparam int ADDR_LSB  = $clog2(W / 8);
    localparam int CNT_W     = $clog2(RAM_BURST_DATA_COUNT + 1);
    localparam logic [CNT_W-1:0] BEAT_END = CNT_W'(RAM_BURST_DATA_COUNT);

    state_t                        r_state;
    state_t                        w_next_state;
    logic [CNT_W-1:0]              r_beat;
    logic [RAM_DEPTH_BITWIDTH-1:0] r_addr;
    logic [LINE_BITS-1:0]          r_line;
    logic [LINE_BITS/8-1:0]        r_mask;
    logic [31:0]                   r_stat_writes;
    logic [31:0]                   r_stat_skipped;

    logic                          w_capture;
    logic                          w_empty;
    logic                          w_busy;
    logic                          w_done;
    logic                          w_cmd_en;
    logic                          w_beat_live;
    logic [W-1:0]                  w_beat_data;
    logic [W/8-1:0]                w_beat_dirty;
    logic                          w_unused_addr;

    assign w_capture     = (r_state == ST_IDLE) && bus.enable;
    assign w_empty       = (bus.line_mask == '0);
    assign w_unused_addr = ^bus.address;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // br_busy is only consulted before beat 0; once started the burst runs
    // to the end, with one trailing cycle (beat index == BEAT_END) for RAM commit.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_cmd_en     = 1'b0;
        w_beat_live  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable) begin
                    if (w_empty)          w_next_state = ST_DONE;
                    else if (bus.br_busy) w_next_state = ST_WAIT_RAM;
                    else                  w_next_state = ST_BURST;
                end
            end
            ST_WAIT_RAM: begin
                w_busy = 1'b1;
                if (!bus.br_busy) w_next_state = ST_BURST;
            end
            ST_BURST: begin
                w_busy      = 1'b1;
                w_cmd_en    = (r_beat == '0);
                w_beat_live = (r_beat != BEAT_END);
                if (r_beat == BEAT_END) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat         <= '0;
            r_addr         <= '0;
            r_line         <= '0;
            r_mask         <= '0;
            r_stat_writes  <= '0;
            r_stat_skipped <= '0;
        end else begin
            if (r_state == ST_BURST) r_beat <= r_beat + CNT_W'(1);
            else                     r_beat <= '0;
            if (w_capture) begin
                r_addr <= bus.address[ADDR_LSB +: RAM_DEPTH_BITWIDTH];
                r_line <= bus.line_data;
                r_mask <= bus.line_mask;
            end
            if (w_capture && w_empty) r_stat_skipped <= r_stat_skipped + 32'd1;
            if (w_cmd_en)             r_stat_writes  <= r_stat_writes + 32'd1;
        end
    end

    line_beat_mux #(
        .BEAT_BITS  (W),
        .BEAT_COUNT (RAM_BURST_DATA_COUNT),
        .IDX_W      (CNT_W)
    ) u_beat_mux (
        .line_data (r_line),
        .line_mask (r_mask),
        .beat      (r_beat),
        .data      (w_beat_data),
        .dirty     (w_beat_dirty)
    );

    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.br_cmd_en    = w_cmd_en;
    assign bus.br_cmd       = w_cmd_en ? CMD_WRITE : CMD_READ;
    assign bus.br_addr      = r_addr;
    assign bus.br_wr_data   = w_beat_live ? w_beat_data : '0;
    assign bus.br_data_mask = w_beat_live ? ~w_beat_dirty : '1;
    assign bus.stat_writes  = r_stat_writes;
    assign bus.stat_skipped = r_stat_skipped;

endmodule
`default_nettype wire
